// File: rtl/sg13g2_io_gpio_pkg.sv
// Shared definitions for the GPIO bank: interrupt edge-mode encodings and
// synchroniser depth limits.
package sg13g2_io_gpio_pkg;

  typedef enum logic [1:0] {
    IRQ_OFF  = 2'b00,
    IRQ_RISE = 2'b01,
    IRQ_FALL = 2'b10,
    IRQ_BOTH = 2'b11
  } irq_mode_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Out-of-range depths are pulled into the legal window.
  function automatic int clamp_sync_stages(input int n);
    if (n < SYNC_STAGES_MIN) begin
      return SYNC_STAGES_MIN;
    end else if (n > SYNC_STAGES_MAX) begin
      return SYNC_STAGES_MAX;
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/sg13g2_io_gpio_bank_if.sv
// Core-side register interface of the GPIO bank (everything except clk/rst/pad).
interface sg13g2_io_gpio_bank_if #(
  parameter int NCH    = 8,
  parameter int FILT_W = 4
);
  logic [NCH-1:0]    c2p;
  logic [NCH-1:0]    c2p_en;
  logic [NCH-1:0]    p2c;
  logic [FILT_W-1:0] filt_len;
  logic [2*NCH-1:0]  irq_mode;
  logic [NCH-1:0]    irq_clr;
  logic [NCH-1:0]    irq_pending;
  logic              irq;

  modport master (
    output c2p, c2p_en, filt_len, irq_mode, irq_clr,
    input  p2c, irq_pending, irq
  );

  modport slave (
    input  c2p, c2p_en, filt_len, irq_mode, irq_clr,
    output p2c, irq_pending, irq
  );
endinterface

// File: rtl/sg13g2_io_gpio_chan.sv
// One GPIO channel: tri-state pad driver, input synchroniser, debounce filter
// and sticky edge-interrupt pending flop.
module sg13g2_io_gpio_chan
  import sg13g2_io_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire               pad,
  input  logic              c2p,
  input  logic              c2p_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [1:0]        irq_mode,
  input  logic              irq_clr,
  output logic              p2c,
  output logic              irq_pending
);
  localparam int SYNC_N = clamp_sync_stages(SYNC_STAGES);
  localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

  logic [SYNC_N-1:0] sync_r;
  logic [FILT_W-1:0] cnt_r;
  logic [FILT_W-1:0] cnt_nxt_s;
  logic              p2c_r;
  logic              p2c_nxt_s;
  logic              pend_r;
  logic              pend_nxt_s;
  logic              s_s;
  logic              edge_hit_s;
  irq_mode_e         mode_s;

  assign pad         = c2p_en ? c2p : 1'bz;
  assign s_s         = sync_r[SYNC_N-1];
  assign mode_s      = irq_mode_e'(irq_mode);
  assign p2c         = p2c_r;
  assign irq_pending = pend_r;

  // Synchroniser chain, debounce counter, filtered value and pending bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
      cnt_r  <= '0;
      p2c_r  <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_N-2:0], pad};
      cnt_r  <= cnt_nxt_s;
      p2c_r  <= p2c_nxt_s;
      pend_r <= pend_nxt_s;
    end
  end

  // Debounce: '>=' lets a shortened filt_len take effect on a count already past it
  always_comb begin
    p2c_nxt_s = p2c_r;
    cnt_nxt_s = '0;
    if (filt_len == '0) begin
      p2c_nxt_s = s_s;
    end else if (s_s == p2c_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r >= (filt_len - CNT_ONE)) begin
      p2c_nxt_s = s_s;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Edge qualification; a new edge outranks a same-cycle clear
  always_comb begin
    edge_hit_s = 1'b0;
    case (mode_s)
      IRQ_OFF:  edge_hit_s = 1'b0;
      IRQ_RISE: edge_hit_s = ~p2c_r & p2c_nxt_s;
      IRQ_FALL: edge_hit_s = p2c_r & ~p2c_nxt_s;
      IRQ_BOTH: edge_hit_s = p2c_r ^ p2c_nxt_s;
      default:  edge_hit_s = 1'b0;
    endcase
    pend_nxt_s = edge_hit_s | (pend_r & ~irq_clr);
  end

endmodule

// File: rtl/sg13g2_io_gpio_bank.sv
// NCH-channel GPIO bank between the pad ring and the core GPIO registers.
module sg13g2_io_gpio_bank
  import sg13g2_io_gpio_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  inout  wire  [NCH-1:0]              pad,
  sg13g2_io_gpio_bank_if.slave        gpio
);
  logic [NCH-1:0] p2c_s;
  logic [NCH-1:0] pend_s;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    sg13g2_io_gpio_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .pad         (pad[i]),
      .c2p         (gpio.c2p[i]),
      .c2p_en      (gpio.c2p_en[i]),
      .filt_len    (gpio.filt_len),
      .irq_mode    (gpio.irq_mode[2*i +: 2]),
      .irq_clr     (gpio.irq_clr[i]),
      .p2c         (p2c_s[i]),
      .irq_pending (pend_s[i])
    );
  end

  assign gpio.p2c         = p2c_s;
  assign gpio.irq_pending = pend_s;
  assign gpio.irq         = |pend_s;

endmodule

// File: tb/tb_sg13g2_io_gpio_bank.sv
// Self-checking bench for sg13g2_io_gpio_bank: behavioural model plus directed
// literal checks, followed by randomized traffic.
module tb_sg13g2_io_gpio_bank;
  localparam int NCH  = 8;
  localparam int SYNC = 2;
  localparam int FW   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] tb_val = '0;
  wire  [NCH-1:0] pad;
  logic           check_en = 1'b0;
  int             n_chk = 0;
  int             n_fail = 0;

  logic [NCH-1:0] m_p2c = '0;
  logic [NCH-1:0] m_pend = '0;
  int             m_run [NCH];
  logic [NCH-1:0] m_q [$];

  sg13g2_io_gpio_bank_if #(.NCH(NCH), .FILT_W(FW)) gpio_if ();

  sg13g2_io_gpio_bank #(.NCH(NCH), .SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
    .clk  (clk),
    .rst  (rst),
    .pad  (pad),
    .gpio (gpio_if.slave)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_tb_drv
    assign pad[i] = gpio_if.c2p_en[i] ? 1'bz : tb_val[i];
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: s is the pad value SYNC edges old; p2c follows s after L
  // consecutive disagreeing compares; pending latches qualifying edges.
  initial begin
    logic [NCH-1:0] pad_now;
    logic [NCH-1:0] s;
    logic [1:0]     md;
    logic           old_v;
    logic           new_v;
    logic           hit;
    for (int i = 0; i < NCH; i++) m_run[i] = 0;
    repeat (SYNC) m_q.push_back('0);
    forever begin
      @(posedge clk);
      pad_now = (gpio_if.c2p_en & gpio_if.c2p) | (~gpio_if.c2p_en & tb_val);
      if (rst) begin
        m_p2c = '0;
        m_pend = '0;
        for (int i = 0; i < NCH; i++) m_run[i] = 0;
        m_q.delete();
        repeat (SYNC) m_q.push_back('0);
      end else begin
        s = m_q.pop_front();
        for (int i = 0; i < NCH; i++) begin
          old_v = m_p2c[i];
          new_v = old_v;
          if (gpio_if.filt_len == 0) begin
            new_v = s[i];
            m_run[i] = 0;
          end else if (s[i] == old_v) begin
            m_run[i] = 0;
          end else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] >= int'(gpio_if.filt_len)) begin
              new_v = s[i];
              m_run[i] = 0;
            end
          end
          md  = gpio_if.irq_mode[2*i +: 2];
          hit = (md[0] && !old_v && new_v) || (md[1] && old_v && !new_v);
          m_pend[i] = hit || (m_pend[i] && !gpio_if.irq_clr[i]);
          m_p2c[i]  = new_v;
        end
        m_q.push_back(pad_now);
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("p2c", 32'(gpio_if.p2c), 32'(m_p2c));
        chk("irq_pending", 32'(gpio_if.irq_pending), 32'(m_pend));
        chk("irq", 32'(gpio_if.irq), 32'(|m_pend));
      end
    end
  end

  initial begin
    gpio_if.c2p      = '0;
    gpio_if.c2p_en   = '0;
    gpio_if.filt_len = '0;
    gpio_if.irq_mode = '0;
    gpio_if.irq_clr  = '0;

    // Reset with random pad values
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tb_val = 8'($urandom());
      @(negedge clk);
      check_en = 1'b1;
    end
    chk("reset_p2c", 32'(gpio_if.p2c), 32'h0);
    chk("reset_pending", 32'(gpio_if.irq_pending), 32'h0);
    chk("reset_irq", 32'(gpio_if.irq), 32'h0);

    // Pad drive on low nibble
    rst = 1'b0;
    gpio_if.c2p_en = 8'h0F;
    gpio_if.c2p    = 8'h05;
    tb_val         = 8'($urandom());
    #1;
    chk("pad_drive", 32'(pad & 8'h0F), 32'h05);

    gpio_if.c2p_en = 8'h00;
    tb_val = 8'h00;
    step(5);

    // Bypass latency and rise interrupt on ch0
    gpio_if.irq_mode = 16'h0001;
    tb_val[0] = 1'b1;
    step(2);
    chk("bypass_early", 32'(gpio_if.p2c[0]), 32'h0);
    step(1);
    chk("bypass_p2c", 32'(gpio_if.p2c[0]), 32'h1);
    chk("bypass_pend", 32'(gpio_if.irq_pending[0]), 32'h1);
    chk("bypass_irq", 32'(gpio_if.irq), 32'h1);

    // Debounce L=5: 4-cycle glitch rejected, long pulse accepted after 2+5
    gpio_if.irq_mode = 16'h00C1;
    gpio_if.filt_len = 4'd5;
    tb_val[3] = 1'b1;
    step(4);
    tb_val[3] = 1'b0;
    step(10);
    chk("glitch_p2c", 32'(gpio_if.p2c[3]), 32'h0);
    chk("glitch_pend", 32'(gpio_if.irq_pending[3]), 32'h0);
    tb_val[3] = 1'b1;
    step(6);
    chk("debounce_early", 32'(gpio_if.p2c[3]), 32'h0);
    step(1);
    chk("debounce_p2c", 32'(gpio_if.p2c[3]), 32'h1);
    step(3);

    // Mode filtering: ch2 fall-only, ch5 both
    gpio_if.filt_len = 4'd0;
    gpio_if.irq_clr  = 8'hFF;
    step(1);
    gpio_if.irq_clr  = 8'h00;
    gpio_if.irq_mode = 16'h0C20;
    tb_val[2] = 1'b1;
    tb_val[5] = 1'b1;
    step(3);
    chk("mode_rise_ch2", 32'(gpio_if.irq_pending[2]), 32'h0);
    chk("mode_rise_ch5", 32'(gpio_if.irq_pending[5]), 32'h1);
    tb_val[2] = 1'b0;
    tb_val[5] = 1'b0;
    step(3);
    chk("mode_fall_all", 32'(gpio_if.irq_pending), 32'h24);

    // Set/clear collision on ch5, then quiet clear
    tb_val[5] = 1'b1;
    step(2);
    gpio_if.irq_clr = 8'h20;
    step(1);
    gpio_if.irq_clr = 8'h00;
    chk("collision_set_wins", 32'(gpio_if.irq_pending[5]), 32'h1);
    gpio_if.irq_clr = 8'h24;
    step(1);
    gpio_if.irq_clr = 8'h00;
    chk("quiet_clear", 32'(gpio_if.irq_pending), 32'h0);
    chk("quiet_clear_irq", 32'(gpio_if.irq), 32'h0);

    // Reset aborts a count in progress on ch1 (L=15)
    gpio_if.filt_len = 4'd15;
    gpio_if.irq_mode = 16'h0004;
    tb_val[1] = 1'b1;
    step(9);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midreset_p2c", 32'(gpio_if.p2c[1]), 32'h0);
    step(16);
    chk("midreset_early", 32'(gpio_if.p2c[1]), 32'h0);
    step(1);
    chk("midreset_p2c_full", 32'(gpio_if.p2c[1]), 32'h1);
    chk("midreset_pend", 32'(gpio_if.irq_pending[1]), 32'h1);

    // Randomized traffic including loopback and mid-count filt_len changes
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < NCH; b++) begin
        if ($urandom_range(0, 7) == 0) tb_val[b] = ~tb_val[b];
      end
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 3) == 0) gpio_if.filt_len = 4'($urandom_range(0, 15));
        else gpio_if.filt_len = 4'($urandom_range(0, 6));
      end
      if ((cyc % 150) == 0) gpio_if.irq_mode = 16'($urandom());
      gpio_if.irq_clr = 8'($urandom()) & 8'($urandom()) & 8'($urandom());
      if ((cyc % 250) == 0) gpio_if.c2p_en = 8'($urandom()) & 8'($urandom());
      if ($urandom_range(0, 9) == 0) gpio_if.c2p = 8'($urandom());
      #1;
      chk("pad_drive_rand", 32'(pad & gpio_if.c2p_en), 32'(gpio_if.c2p & gpio_if.c2p_en));
    end

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
